// File: rtl/reloj_display_scan_if.sv
// Digit/display bundle between the clock core, the scan driver and the pads.
// Carries the BCD time digits in and the scanned segment/digit-select lines out.
// No handshake: digits are level signals and the display lines update every cycle.
interface reloj_display_scan_if;
    logic [3:0] M0;
    logic [3:0] M1;
    logic [3:0] H0;
    logic [1:0] H1;
    logic       Dots;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    // Clock-core side: drives the digits and observes the display lines.
    modport master (
        output M0, M1, H0, H1, Dots,
        input  seg, dp, an
    );

    // Scan driver side: consumes the digits and drives the display lines.
    modport slave (
        input  M0, M1, H0, H1, Dots,
        output seg, dp, an
    );
endinterface

// File: rtl/reloj_display_scan.sv
// Time-multiplexed 4-digit 7-segment scanner with per-frame snapshot and per-slot blanking.
// Latency: one cycle from scan state to registered pins; frame period is 4*SCAN_DIV cycles.
// No backpressure; optional macro LEADING_ZERO_BLANK_EN darkens digit 3 when the hours tens is 0.
module reloj_display_scan #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned BLANK      = 8,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    reloj_display_scan_if.slave   bus
);

    localparam logic [15:0] P_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic        DP_OFF   = ACTIVE_LOW;
    localparam logic [3:0]  AN_OFF   = {4{ACTIVE_LOW}};

    // Scan state
    logic [15:0] p_q, p_d;
    logic [1:0]  i_q, i_d;

    // Frame snapshot; H1 is held zero-extended so all digits share one decoder path
    logic [3:0]  m0_q, m0_d;
    logic [3:0]  m1_q, m1_d;
    logic [3:0]  h0_q, h0_d;
    logic [3:0]  h1_q, h1_d;
    logic        dots_q, dots_d;

    // Registered pins
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  an_q, an_d;

    logic [3:0]  cur_digit;
    logic        slot_blank;
    logic        frame_start;

    function automatic logic [6:0] decode_7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40; // non-BCD shows a dash
        endcase
        return s;
    endfunction

    // Prescaler and digit index advance; snapshot captured on the first blank cycle of a frame
    always_comb begin
        p_d         = p_q + 16'd1;
        i_d         = i_q;
        frame_start = (p_q == 16'd0) && (i_q == 2'd0);
        m0_d        = m0_q;
        m1_d        = m1_q;
        h0_d        = h0_q;
        h1_d        = h1_q;
        dots_d      = dots_q;
        if (p_q == P_LAST) begin
            p_d = 16'd0;
            i_d = i_q + 2'd1;
        end
        if (frame_start) begin
            m0_d   = bus.M0;
            m1_d   = bus.M1;
            h0_d   = bus.H0;
            h1_d   = {2'b00, bus.H1};
            dots_d = bus.Dots;
        end
    end

    // Pin values for the current scan state, polarity applied last
    always_comb begin
        cur_digit  = m0_q;
        slot_blank = (32'(p_q) < BLANK);
        seg_d      = SEG_OFF;
        dp_d       = DP_OFF;
        an_d       = AN_OFF;
        case (i_q)
            2'd0:    cur_digit = m0_q;
            2'd1:    cur_digit = m1_q;
            2'd2:    cur_digit = h0_q;
            default: cur_digit = h1_q;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((i_q == 2'd3) && (h1_q == 4'd0)) begin
            slot_blank = 1'b1;
        end
`endif
        if (!slot_blank) begin
            an_d  = (4'b0001 << i_q) ^ AN_OFF;
            seg_d = decode_7seg(cur_digit) ^ SEG_OFF;
            dp_d  = ((i_q == 2'd2) && dots_q) ^ DP_OFF;
        end
    end

    // State, snapshot and output registers; reset drives pins to their inactive level
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q    <= 16'd0;
            i_q    <= 2'd0;
            m0_q   <= 4'd0;
            m1_q   <= 4'd0;
            h0_q   <= 4'd0;
            h1_q   <= 4'd0;
            dots_q <= 1'b0;
            seg_q  <= SEG_OFF;
            dp_q   <= DP_OFF;
            an_q   <= AN_OFF;
        end else begin
            p_q    <= p_d;
            i_q    <= i_d;
            m0_q   <= m0_d;
            m1_q   <= m1_d;
            h0_q   <= h0_d;
            h1_q   <= h1_d;
            dots_q <= dots_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_reloj_display_scan.sv
// Scoreboard bench for reloj_display_scan: SCAN_DIV=4, BLANK=1, active-high and active-low copies.
// Stimulus pushes one hand-derived expectation per clock edge; a negedge monitor pops and compares.
// The active-low copy is checked against the bitwise inverse of the same expectation.
module tb_reloj_display_scan;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reloj_display_scan_if bus_h ();
    reloj_display_scan_if bus_l ();

    reloj_display_scan #(.SCAN_DIV(4), .BLANK(1), .ACTIVE_LOW(1'b0)) dut_h (
        .clk (clk),
        .rst (rst),
        .bus (bus_h.slave)
    );

    reloj_display_scan #(.SCAN_DIV(4), .BLANK(1), .ACTIVE_LOW(1'b1)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit H1_ZERO_LIT = 1'b0;
`else
    localparam bit H1_ZERO_LIT = 1'b1;
`endif

    task automatic drive(input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] h0,
                         input logic [1:0] h1, input logic dots);
        bus_h.M0 = m0; bus_h.M1 = m1; bus_h.H0 = h0; bus_h.H1 = h1; bus_h.Dots = dots;
        bus_l.M0 = m0; bus_l.M1 = m1; bus_l.H0 = h0; bus_l.H1 = h1; bus_l.Dots = dots;
    endtask

    // Expectation is for the pins right after the next rising edge
    task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic dp);
        exp_t e;
        e.an  = an;
        e.seg = seg;
        e.dp  = dp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One slot: one blank cycle, then three lit cycles (or three dark ones if lit=0)
    task automatic run_slot(input int d, input logic [6:0] s, input logic dots, input bit lit);
        logic [3:0] oh;
        oh = 4'b0001 << d;
        step(4'b0000, 7'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (lit) step(oh, s, (d == 2) && dots);
            else     step(4'b0000, 7'h00, 1'b0);
        end
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic dots, input bit lit3);
        run_slot(0, s0, dots, 1'b1);
        run_slot(1, s1, dots, 1'b1);
        run_slot(2, s2, dots, 1'b1);
        run_slot(3, s3, dots, lit3);
    endtask

    // Monitor: one expectation per edge, compared half a cycle later
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            edge_n++;
            total++;
            if ({bus_h.an, bus_h.seg, bus_h.dp} !== {e.an, e.seg, e.dp}) begin
                bad++;
                $display("FAIL active_high edge=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         edge_n, bus_h.an, bus_h.seg, bus_h.dp, e.an, e.seg, e.dp);
            end
            total++;
            if ({bus_l.an, bus_l.seg, bus_l.dp} !== ~{e.an, e.seg, e.dp}) begin
                bad++;
                $display("FAIL active_low edge=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         edge_n, bus_l.an, bus_l.seg, bus_l.dp, ~e.an, ~e.seg, ~e.dp);
            end
        end
    end

    initial begin
        // Reset with arbitrary inputs: pins inactive
        rst = 1'b1;
        drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        step(4'b0000, 7'h00, 1'b0);
        step(4'b0000, 7'h00, 1'b0);

        // Basic scan 12:34, no colon
        rst = 1'b0;
        drive(4'd4, 4'd3, 4'd2, 2'd1, 1'b0);
        frame(7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, 1'b1);

        // Non-BCD minutes units shows a dash; colon on digit 2 only
        drive(4'hC, 4'd3, 4'd2, 2'd1, 1'b1);
        frame(7'h40, 7'h4F, 7'h5B, 7'h06, 1'b1, 1'b1);

        // Mid-frame input change is held off until the next frame
        drive(4'd4, 4'd3, 4'd2, 2'd1, 1'b0);
        run_slot(0, 7'h66, 1'b0, 1'b1);
        drive(4'd4, 4'd7, 4'd2, 2'd1, 1'b0);
        run_slot(1, 7'h4F, 1'b0, 1'b1);
        run_slot(2, 7'h5B, 1'b0, 1'b1);
        run_slot(3, 7'h06, 1'b0, 1'b1);
        frame(7'h66, 7'h07, 7'h5B, 7'h06, 1'b0, 1'b1);

        // Reset during digit 2 slot: inactive on that edge, restart at digit 0
        drive(4'd4, 4'd3, 4'd2, 2'd1, 1'b1);
        run_slot(0, 7'h66, 1'b1, 1'b1);
        run_slot(1, 7'h4F, 1'b1, 1'b1);
        step(4'b0000, 7'h00, 1'b0);
        step(4'b0100, 7'h5B, 1'b1);
        rst = 1'b1;
        step(4'b0000, 7'h00, 1'b0);
        rst = 1'b0;
        drive(4'd9, 4'd5, 4'd8, 2'd2, 1'b0);
        frame(7'h6F, 7'h6D, 7'h7F, 7'h5B, 1'b0, 1'b1);

        // Leading zero on hours tens
        drive(4'd0, 4'd6, 4'd9, 2'd0, 1'b1);
        frame(7'h3F, 7'h7D, 7'h6F, 7'h3F, 1'b1, H1_ZERO_LIT);

        // Back to a non-zero hours tens
        drive(4'd1, 4'd5, 4'd3, 2'd2, 1'b0);
        frame(7'h06, 7'h6D, 7'h4F, 7'h5B, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
